serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, meaning data bits per frame (legal 4..16).
REQ-002 Parameter PARITY_EN, default 1, meaning 1 = even-parity bit present after data, 0 = no parity bit.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in  input  1  serial bit stream, one bit per clk (the serial output of the upstream shift-register stage).
REQ-006 Port out_data  output  DATA_W  received data word.
REQ-007 Port out_valid  output  1  out_data holds an unconsumed word.
REQ-008 Port out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high at posedge.
REQ-009 Port parity_err  output  1  one-cycle pulse: parity mismatch, frame discarded.
REQ-010 Port frame_err  output  1  one-cycle pulse: stop bit wrong, frame discarded.
REQ-011 Port overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.

Function
REQ-012 Frame format SHALL be: idle level 0, start bit 1, DATA_W data bits LSB-first, parity bit (if PARITY_EN), stop bit 0.
REQ-013 The bit on in SHALL be sampled at every posedge clk; no oversampling.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: in=1 -> DATA with bit counter cleared; in=0 -> stay IDLE.
REQ-016 DATA: each sample shifts into bit position counter; after DATA_W samples -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
REQ-017 PARITY: sampled bit SHALL equal XOR of the DATA_W data bits; mismatch recorded; -> STOP unconditionally.
REQ-018 STOP: -> IDLE unconditionally; the stop sample is never treated as a start bit.
REQ-019 On the STOP sample: stop=1 -> frame_err pulse; else recorded parity mismatch -> parity_err pulse; else frame is good. frame_err takes priority; at most one error pulse per frame.
REQ-020 Good frame SHALL be loaded into the holding register at the posedge that samples the stop bit; out_valid high from that edge (latency: stop-bit edge, zero extra cycles).
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 out_valid SHALL clear at a posedge where out_valid=1 and out_ready=1 and no new good frame completes.
REQ-023 Good frame completing while out_valid=1 and out_ready=0: new word dropped, old word kept, overrun pulses one cycle.
REQ-024 Good frame completing while out_valid=1 and out_ready=1: old word consumed, new word loaded, out_valid stays 1, no overrun.
REQ-025 Errored frames SHALL never modify out_data or out_valid.
REQ-026 Back-to-back frames (start bit in the cycle after stop) SHALL be received without loss.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, shift register 0, out_data 0, out_valid 0, parity_err 0, frame_err 0, overrun 0, independent of clk.
REQ-028 Reset mid-frame SHALL abandon the partial frame without any error pulse; reception resumes with the first start bit after rst falls.

Structure
REQ-029 Package serial_frame_pkg SHALL hold the FSM state type, DATA_W default, and constants IDLE_LEVEL=0, START_LEVEL=1, STOP_LEVEL=0.
REQ-030 The holding register and its valid/ready/overrun logic SHALL be sub-module rx_hold_reg; FSM, counter and shift register stay in serial_frame_rx.

Verification (DATA_W=8, PARITY_EN=1)
REQ-031 Reset, send 1,{1,0,1,0,0,1,0,1},0,0 (0xA5, parity 0, stop 0), out_ready=0 -> out_data=0xA5, out_valid=1 from stop edge, held until out_ready=1.
REQ-032 Send 0x01 with parity bit 0 -> parity_err one-cycle pulse, out_valid stays 0.
REQ-033 Send 0x3C with correct parity, stop bit 1 -> frame_err pulse only, FSM in IDLE next cycle, out_valid unchanged.
REQ-034 Back-to-back 0x11 then 0x22, out_ready=0 -> overrun pulse at second stop edge, out_data=0x11.
REQ-035 Same as REQ-034 with out_ready=1 on the second stop edge only -> out_data=0x22, out_valid=1, overrun never asserted.
REQ-036 Assert rst after 4 data bits of 0xFF -> all outputs 0, no error pulse; subsequent 0x5A frame received correctly.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package serial_frame_pkg;
    localparam int   DATA_W_DEF  = 8;
    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;
endpackage

// File: rtl/rx_hold_reg.sv
// Single-entry holding register with valid/ready handshake and overrun flag.
module rx_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overrun
);
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              w_free;

    // The slot is usable if empty or being drained on this same edge.
    assign w_free = !r_valid || i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_free;
            if (i_load && w_free) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, LSB-first data, optional even parity, stop.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         r_state;
    rx_state_t         w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_bad;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              w_last_bit;
    logic              w_good;
    logic              w_perr;
    logic              w_ferr;

    assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in == START_LEVEL) w_next = DATA;
            DATA:    if (w_last_bit) w_next = PARITY_EN ? PARITY : STOP;
            PARITY:  w_next = STOP;
            STOP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Frame verdict is formed on the stop sample; wrong stop level wins.
    always_comb begin
        w_ferr = 1'b0;
        w_perr = 1'b0;
        w_good = 1'b0;
        if (r_state == STOP) begin
            w_ferr = (in != STOP_LEVEL);
            w_perr = !w_ferr && r_par_bad;
            w_good = !w_ferr && !r_par_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in == START_LEVEL) begin
                    r_cnt     <= '0;
                    r_par_bad <= 1'b0;
                end
                DATA: begin
                    r_shift[r_cnt] <= in;
                    r_cnt          <= r_cnt + 1'b1;
                end
                PARITY:  r_par_bad <= (in != (^r_shift));
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
        end
    end

    rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_good),
        .i_data    (r_shift),
        .i_ready   (out_ready),
        .o_data    (out_data),
        .o_valid   (out_valid),
        .o_overrun (overrun)
    );

    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized scoreboard bench for serial_frame_rx (DATA_W=8, even parity).
module tb_serial_frame_rx;
    localparam int DW = 8;
    localparam int EV_NONE = 0, EV_GOOD = 1, EV_PERR = 2, EV_FERR = 3, EV_OVR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_s = 1'b0;
    logic          rdy = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid, parity_err, frame_err, overrun;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] wq[$];
    int            eq[$];
    bit            m_full = 1'b0;
    logic [DW-1:0] m_word = '0;
    bit            mon_en = 1'b0;

    serial_frame_rx #(.DATA_W(DW), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_s),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (rdy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit pick(input int mode);
        if (mode == 2) return bit'($urandom_range(1, 0));
        return bit'(mode);
    endfunction

    // One serial bit per clock; reference holding-slot rules applied at the edge.
    task automatic tick(input logic b, input logic r, input int ev, input logic [DW-1:0] w);
        in_s = b;
        rdy  = r;
        @(posedge clk);
        if (ev == EV_GOOD) begin
            if (!m_full || r) begin
                m_full = 1'b1;
                m_word = w;
                wq.push_back(w);
            end else begin
                eq.push_back(EV_OVR);
            end
        end else begin
            if (ev == EV_PERR || ev == EV_FERR) eq.push_back(ev);
            if (m_full && r) m_full = 1'b0;
        end
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit bp, input bit bs,
                              input int rmode, input int smode);
        int ev;
        tick(1'b1, pick(rmode), EV_NONE, w);
        for (int i = 0; i < DW; i++) tick(w[i], pick(rmode), EV_NONE, w);
        tick((^w) ^ bp, pick(rmode), EV_NONE, w);
        ev = bs ? EV_FERR : (bp ? EV_PERR : EV_GOOD);
        tick(bs, pick(smode), ev, w);
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) tick(1'b0, pick(rmode), EV_NONE, '0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_perr"}, parity_err, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    // Monitor: checks holding state every cycle and pops scoreboard entries.
    always @(negedge clk) begin
        int npulse, kind, expk;
        logic [DW-1:0] expw;
        if (mon_en && !rst) begin
            chk("valid_state", out_valid, m_full);
            if (out_valid) chk("held_data", out_data, m_word);
            npulse = parity_err + frame_err + overrun;
            if (npulse > 1) chk("pulse_count", npulse, 1);
            else if (npulse == 1) begin
                kind = parity_err ? EV_PERR : (frame_err ? EV_FERR : EV_OVR);
                if (eq.size() == 0) chk("unexpected_pulse", kind, EV_NONE);
                else begin
                    expk = eq.pop_front();
                    chk("pulse_kind", kind, expk);
                end
            end
            if (out_valid && rdy) begin
                if (wq.size() == 0) chk("unexpected_word", out_data, -1);
                else begin
                    expw = wq.pop_front();
                    chk("word", out_data, expw);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2, 0);

        send_frame(8'hA5, 0, 0, 0, 0);
        chk("a5_valid", out_valid, 1);
        chk("a5_data", out_data, 8'hA5);
        idle(4, 0);
        chk("a5_held", out_data, 8'hA5);
        idle(2, 1);

        send_frame(8'h01, 1, 0, 0, 0);
        chk("perr_pulse", parity_err, 1);
        idle(1, 0);
        chk("perr_one_cycle", parity_err, 0);

        send_frame(8'h3C, 0, 1, 0, 0);
        chk("ferr_pulse", frame_err, 1);
        chk("ferr_no_perr", parity_err, 0);
        idle(2, 0);

        send_frame(8'h11, 0, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0, 0);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_keep", out_data, 8'h11);
        idle(2, 0);
        idle(2, 1);

        send_frame(8'h11, 0, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0, 1);
        chk("swap_ovr", overrun, 0);
        chk("swap_data", out_data, 8'h22);
        chk("swap_valid", out_valid, 1);
        idle(2, 0);
        idle(2, 1);

        tick(1'b1, 1'b0, EV_NONE, '0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, EV_NONE, '0);
        #2;
        rst = 1'b1;
        m_full = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_s = 1'b0;
        idle(2, 0);
        send_frame(8'h5A, 0, 0, 0, 0);
        chk("post_rst_data", out_data, 8'h5A);
        idle(2, 1);

        for (int f = 0; f < 200; f++) begin
            logic [DW-1:0] w;
            bit bp, bs;
            w  = DW'($urandom);
            bp = ($urandom_range(5, 0) == 0);
            bs = ($urandom_range(5, 0) == 0);
            send_frame(w, bp, bs, 2, 2);
            idle($urandom_range(3, 0), 2);
        end

        idle(4, 1);
        chk("words_left", wq.size(), 0);
        chk("events_left", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
